// File: rtl/fft_frame_sequencer_pkg.sv
// Shared definitions for the 8-point FFT frame sequencer: state encoding,
// default frame geometry and the FFT pipeline latency.
package fft_frame_sequencer_pkg;

    localparam int N_PTS_DEF   = 8;
    localparam int IDX_W_DEF   = 3;
    localparam int FFT_LAT_DEF = 4;   // matches the eight_pt_fft pipeline depth
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } seq_state_e;

    // Width of a down-counter that has to hold FFT_LAT-1.
    function automatic int lat_cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Sample-side, FFT-side and bin-side signals of the frame sequencer.
// master = sequencer, slave = surrounding datapath / host.
interface fft_frame_sequencer_if
    import fft_frame_sequencer_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic             cap_we;
    logic [IDX_W-1:0] cap_idx;
    logic             fft_start;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             frame_done;
    logic             ovf;
    logic             ovf_clr;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        input  en, in_valid, out_ready, ovf_clr,
        output in_ready, cap_we, cap_idx, fft_start, out_valid, out_idx,
               frame_done, ovf, frame_cnt
    );

    modport slave (
        output en, in_valid, out_ready, ovf_clr,
        input  in_ready, cap_we, cap_idx, fft_start, out_valid, out_idx,
               frame_done, ovf, frame_cnt
    );

endinterface

// File: rtl/fft_frame_sequencer_seq_down_counter.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module seq_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller for capture -> FFT -> serialiser: gates sample capture,
// pulses fft_start, waits out the FFT latency and streams bins downstream.
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int N_PTS   = N_PTS_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int FFT_LAT = FFT_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    fft_frame_sequencer_if.master  bus
);

    localparam int               LAT_W    = lat_cnt_w(FFT_LAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(FFT_LAT - 1);

    seq_state_e       state;
    logic             in_ready_r;
    logic             fft_start_r;
    logic             out_valid_r;
    logic             frame_done_r;
    logic             ovf_r;
    logic [IDX_W-1:0] cap_idx_r;
    logic [IDX_W-1:0] out_idx_r;
    logic [CNT_W-1:0] frame_cnt_r;

    logic accept;
    logic last_accept;
    logic drain_hs;
    logic lat_done;

    assign accept      = bus.in_valid & in_ready_r;
    assign last_accept = accept & (cap_idx_r == LAST_IDX);
    assign drain_hs    = out_valid_r & bus.out_ready;

    // Loaded on the last accept so it reads FFT_LAT-1 in the fft_start cycle
    // and reaches zero in the final COMPUTE cycle.
    seq_down_counter #(
        .W (LAT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (last_accept),
        .load_val (LAT_LOAD),
        .dec      (state == ST_COMPUTE),
        .done     (lat_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            in_ready_r   <= 1'b0;
            fft_start_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            ovf_r        <= 1'b0;
            cap_idx_r    <= '0;
            out_idx_r    <= '0;
            frame_cnt_r  <= '0;
        end else begin
            fft_start_r  <= 1'b0;
            frame_done_r <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.en) begin
                        state      <= ST_CAPTURE;
                        in_ready_r <= 1'b1;
                        cap_idx_r  <= '0;
                    end
                end

                ST_CAPTURE: begin
                    if (accept) begin
                        cap_idx_r <= cap_idx_r + IDX_W'(1);
                        if (cap_idx_r == LAST_IDX) begin
                            state       <= ST_COMPUTE;
                            in_ready_r  <= 1'b0;
                            fft_start_r <= 1'b1;
                        end
                    end
                end

                ST_COMPUTE: begin
                    if (lat_done) begin
                        state       <= ST_DRAIN;
                        out_valid_r <= 1'b1;
                        out_idx_r   <= '0;
                    end
                end

                ST_DRAIN: begin
                    if (drain_hs) begin
                        out_idx_r <= out_idx_r + IDX_W'(1);
                        if (out_idx_r == LAST_IDX) begin
                            out_valid_r  <= 1'b0;
                            frame_done_r <= 1'b1;
                            frame_cnt_r  <= frame_cnt_r + CNT_W'(1);
                            // en is only honoured here and in IDLE
                            if (bus.en) begin
                                state      <= ST_CAPTURE;
                                in_ready_r <= 1'b1;
                                cap_idx_r  <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A dropped sample outranks a same-cycle clear.
            if (bus.in_valid && !in_ready_r && (state != ST_IDLE)) begin
                ovf_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.cap_we     = accept;
    assign bus.cap_idx    = cap_idx_r;
    assign bus.fft_start  = fft_start_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_idx    = out_idx_r;
    assign bus.frame_done = frame_done_r;
    assign bus.ovf        = ovf_r;
    assign bus.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: a cycle table for one full frame
// plus hand-written sequences for backpressure, overflow, en drop, reset and wrap.
module tb_fft_frame_sequencer;

    logic clk;
    logic rst;

    fft_frame_sequencer_if #(.IDX_W(3), .CNT_W(4)) bus ();

    fft_frame_sequencer #(
        .N_PTS   (8),
        .IDX_W   (3),
        .FFT_LAT (4),
        .CNT_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ins   = {en, in_valid, out_ready, ovf_clr}
    // flags = {in_ready, cap_we, fft_start, out_valid, frame_done, ovf}
    typedef struct {
        logic [3:0] ins;
        logic [5:0] flags;
        logic [2:0] cidx;
        logic [2:0] oidx;
        logic [3:0] fcnt;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] snapshot();
        return {bus.in_ready, bus.cap_we, bus.fft_start, bus.out_valid, bus.frame_done,
                bus.ovf, bus.cap_idx, bus.out_idx, bus.frame_cnt};
    endfunction

    task automatic do_reset();
        rst           = 1'b0;
        bus.en        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        #2;
        chk("reset_state", 32'(snapshot()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        logic [2:0] exp_idx;
        int         delivered;
        bit         found;
        bit         saw_fd;
        int         nframes;
        int         last_cyc;
        int         cyc;

        // ---------------- test 1: one full frame, cycle by cycle ----------------
        vecs[0]  = '{4'b1110, 6'b000000, 3'd0, 3'd0, 4'd0};  // IDLE, sample ignored
        vecs[1]  = '{4'b1110, 6'b110000, 3'd0, 3'd0, 4'd0};
        vecs[2]  = '{4'b1110, 6'b110000, 3'd1, 3'd0, 4'd0};
        vecs[3]  = '{4'b1110, 6'b110000, 3'd2, 3'd0, 4'd0};
        vecs[4]  = '{4'b1110, 6'b110000, 3'd3, 3'd0, 4'd0};
        vecs[5]  = '{4'b1110, 6'b110000, 3'd4, 3'd0, 4'd0};
        vecs[6]  = '{4'b1110, 6'b110000, 3'd5, 3'd0, 4'd0};
        vecs[7]  = '{4'b1110, 6'b110000, 3'd6, 3'd0, 4'd0};
        vecs[8]  = '{4'b1110, 6'b110000, 3'd7, 3'd0, 4'd0};
        vecs[9]  = '{4'b1010, 6'b001000, 3'd0, 3'd0, 4'd0};  // fft_start
        vecs[10] = '{4'b1010, 6'b000000, 3'd0, 3'd0, 4'd0};
        vecs[11] = '{4'b1010, 6'b000000, 3'd0, 3'd0, 4'd0};
        vecs[12] = '{4'b1010, 6'b000000, 3'd0, 3'd0, 4'd0};
        vecs[13] = '{4'b1010, 6'b000100, 3'd0, 3'd0, 4'd0};  // first bin
        vecs[14] = '{4'b1010, 6'b000100, 3'd0, 3'd1, 4'd0};
        vecs[15] = '{4'b1010, 6'b000100, 3'd0, 3'd2, 4'd0};
        vecs[16] = '{4'b1010, 6'b000100, 3'd0, 3'd3, 4'd0};
        vecs[17] = '{4'b1010, 6'b000100, 3'd0, 3'd4, 4'd0};
        vecs[18] = '{4'b1010, 6'b000100, 3'd0, 3'd5, 4'd0};
        vecs[19] = '{4'b1010, 6'b000100, 3'd0, 3'd6, 4'd0};
        vecs[20] = '{4'b0010, 6'b000100, 3'd0, 3'd7, 4'd0};  // last bin, en dropped
        vecs[21] = '{4'b0010, 6'b000010, 3'd0, 3'd0, 4'd1};  // frame_done
        vecs[22] = '{4'b0010, 6'b000000, 3'd0, 3'd0, 4'd1};

        do_reset();
        for (int i = 0; i < 23; i++) begin
            {bus.en, bus.in_valid, bus.out_ready, bus.ovf_clr} = vecs[i].ins;
            #1;
            checks++;
            if (snapshot() !== {vecs[i].flags, vecs[i].cidx, vecs[i].oidx, vecs[i].fcnt}) begin
                errors++;
                $display("FAIL t1_row%0d actual=%b expected=%b", i, snapshot(),
                         {vecs[i].flags, vecs[i].cidx, vecs[i].oidx, vecs[i].fcnt});
            end
            tick();
        end

        // ---------------- test 2: output backpressure 1,0,0,1 ----------------
        do_reset();
        bus.en = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = bus.in_ready;
            if (bus.out_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t2_reach_drain", 32'(found), 32'd1);
        bus.in_valid = 1'b0;
        bus.en       = 1'b0;
        pat          = 4'b1001;
        exp_idx      = 3'd0;
        delivered    = 0;
        for (int c = 0; c < 40 && delivered < 8; c++) begin
            bus.out_ready = pat[c % 4];
            #1;
            chk("t2_out_valid_held", 32'(bus.out_valid), 32'd1);
            chk("t2_out_idx", 32'(bus.out_idx), 32'(exp_idx));
            if (bus.out_ready) begin
                exp_idx++;
                delivered++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        chk("t2_delivered", 32'(delivered), 32'd8);
        chk("t2_frame_done", 32'(bus.frame_done), 32'd1);
        chk("t2_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("t2_valid_drop", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t2_done_one_cycle", 32'(bus.frame_done), 32'd0);
        chk("t2_idle_in_ready", 32'(bus.in_ready), 32'd0);

        // ---------------- test 3: overflow set/clear priority ----------------
        do_reset();
        bus.en        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        repeat (9) tick();
        chk("t3_fft_start", 32'(bus.fft_start), 32'd1);
        chk("t3_ovf_not_yet", 32'(bus.ovf), 32'd0);
        tick();
        chk("t3_ovf_set", 32'(bus.ovf), 32'd1);
        repeat (3) tick();
        chk("t3_in_drain", 32'(bus.out_valid), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        chk("t3_set_beats_clr", 32'(bus.ovf), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("t3_ovf_cleared", 32'(bus.ovf), 32'd0);
        chk("t3_idx_held", 32'(bus.out_idx), 32'd0);
        bus.ovf_clr = 1'b0;

        // ---------------- test 4: en dropped mid-capture ----------------
        do_reset();
        bus.en        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("t4_cap_idx3", 32'(bus.cap_idx), 32'd3);
        bus.en = 1'b0;
        found  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = bus.in_ready;
            tick();
            if (bus.frame_done) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_frame_completed", 32'(found), 32'd1);
        chk("t4_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_idle_in_ready", 32'(bus.in_ready), 32'd0);
            chk("t4_idle_no_we", 32'(bus.cap_we), 32'd0);
            chk("t4_idle_no_ovf", 32'(bus.ovf), 32'd0);
        end

        // ---------------- test 5: reset in DRAIN at out_idx=5 ----------------
        bus.en = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            bus.in_valid = bus.in_ready;
            if (bus.out_valid && bus.out_idx == 3'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_reach_idx5", 32'(found), 32'd1);
        chk("t5_pre_cnt", 32'(bus.frame_cnt), 32'd1);
        #2;
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("t5_async_outputs_zero", 32'(snapshot()), 32'd0);
        saw_fd = 1'b0;
        repeat (2) begin
            tick();
            if (bus.frame_done) saw_fd = 1'b1;
        end
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) begin
            tick();
            if (bus.frame_done) saw_fd = 1'b1;
        end
        chk("t5_no_frame_done", 32'(saw_fd), 32'd0);
        chk("t5_frame_cnt_zero", 32'(bus.frame_cnt), 32'd0);
        chk("t5_idle_after", 32'(bus.in_ready), 32'd0);

        // ---------------- test 6: back-to-back frames, counter wrap ----------------
        do_reset();
        bus.en        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        nframes  = 0;
        last_cyc = 0;
        cyc      = 0;
        while (cyc < 400 && nframes < 16) begin
            tick();
            cyc++;
            if (bus.frame_done) begin
                nframes++;
                chk("t6_frame_cnt", 32'(bus.frame_cnt), 32'(nframes % 16));
                if (nframes == 1) chk("t6_first_done_cycle", 32'(cyc), 32'd21);
                else              chk("t6_frame_period", 32'(cyc - last_cyc), 32'd20);
                last_cyc = cyc;
            end
        end
        chk("t6_frames_seen", 32'(nframes), 32'd16);
        chk("t6_wrapped_zero", 32'(bus.frame_cnt), 32'd0);
        chk("t6_ovf_sticky", 32'(bus.ovf), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
